// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: single-cycle multiply, 32-step restoring divide,
// registered result/rd with a one-cycle done strobe and a busy stall for the pipeline.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
    logic              q_neg_q, r_neg_q;
    logic [4:0]        count;

    logic              accept;
    logic              div_signed, div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   special_res, a_mag, b_mag;
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] a_ext, b_ext, product;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     partial, diff;
    logic [XLEN-1:0]   rem_step, quo_step, div_res;

    assign accept      = (state == IDLE) && start && !flush;
    assign div_signed  = !funct3[0];
    assign div_zero    = (op_b == '0);
    assign div_ovf     = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign div_special = funct3[2] && (div_zero || div_ovf);

    // Overflow quotient equals the dividend itself, so op_a covers both special DIV results
    assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0   : op_a);

    assign a_mag = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

    assign a_sext  = (op_q == 2'b01) || (op_q == 2'b10);
    assign b_sext  = (op_q == 2'b01);
    assign a_ext   = {{XLEN{a_sext & a_q[XLEN-1]}}, a_q};
    assign b_ext   = {{XLEN{b_sext & b_q[XLEN-1]}}, b_q};
    assign product = a_ext * b_ext;
    assign mul_res = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // One restoring step: shift the next dividend bit in, keep the difference if it fits
    assign partial  = {rem_q, quo_q[XLEN-1]};
    assign diff     = partial - {1'b0, dvs_q};
    assign rem_step = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign div_res  = op_q[1] ? (r_neg_q ? -rem_step : rem_step)
                              : (q_neg_q ? -quo_step : quo_step);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!funct3[2])       state_next = MUL;
                    else if (div_special) state_next = DONE;
                    else                  state_next = DIV;
                end
            end
            MUL:  state_next = DONE;
            DIV:  if (count == 5'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            count   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= funct3[1:0];
                        a_q     <= op_a;
                        b_q     <= op_b;
                        rd_q    <= rd_in;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        rem_q   <= '0;
                        count   <= '0;
                        q_neg_q <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        r_neg_q <= div_signed && op_a[XLEN-1];
                        if (div_special) begin
                            result <= special_res;
                            rd_out <= rd_in;
                        end
                    end
                end
                MUL: begin
                    if (!flush) begin
                        result <= mul_res;
                        rd_out <= rd_q;
                    end
                end
                DIV: begin
                    if (!flush) begin
                        quo_q <= quo_step;
                        rem_q <= rem_step;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            result <= div_res;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execute unit placed beside the ALU in the EX stage. It consumes the two operand values read from the register file (`rs1`/`rs2` data) and the destination register index. It produces a 32-bit result plus `rd` index and a one-cycle `done` strobe for the writeback path, which drives the register file write port. The pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only when `busy`=0.
- `funct3`  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  32  rs1 value.
- `op_b`  input  32  rs2 value.
- `rd_in`  input  5  destination register.
- `flush`  input  1  abort in-flight op (branch mispredict/trap).
- `busy`  output  1  unit occupied; pipeline must hold EX.
- `done`  output  1  one-cycle strobe; `result`/`rd_out` valid.
- `result`  output  32  operation result.
- `rd_out`  output  5  destination register of the completed op.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If `start` is high and `flush` is low, latch `funct3`, `op_a`, `op_b`, `rd_in`.
  - funct3[2]=0: go to MUL.
  - Division special case (`op_b`=0, or signed overflow): go to DONE with the result precomputed.
  - Otherwise: go to DIV.
- MUL: one cycle. Form the 64-bit product from sign-extended operands:
  - MUL: low 32 bits.
  - MULH: signed×signed, high 32 bits.
  - MULHSU: signed a × unsigned b, high 32 bits.
  - MULHU: unsigned×unsigned, high 32 bits.
  - Register the result, then go to DONE.
- DIV: restoring division on 32-bit magnitudes, 1 quotient bit per cycle, 32 iterations counted by a 5-bit counter. Then apply signs and go to DONE.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `op_a`.
  - DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000; the matching REM → 0.
- DONE: `done`=1 for exactly this cycle, then go to IDLE. `start` in DONE is ignored.
- `result` and `rd_out` hold their values after `done` until the next completion.
- `rd_in`=0 is still executed and strobed; writeback discards it.
- `flush`:
  - In any state, forces IDLE on the next edge. No `done` is generated for the aborted op. `result`/`rd_out` are unchanged.
  - `flush` and `start` in the same cycle: the flush wins and the start is dropped.
- `rst`: forces IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, iteration counter=0. Reset mid-division discards the op.

## Timing
- `start` is accepted at edge E0 (`busy`=0 in that cycle).
- `busy` is high from the cycle after E0 through the `done` cycle inclusive.
- Multiply: `done` in cycle 2 after E0 (MUL cycle, then DONE cycle). Latency 2.
- Division special case: `done` in cycle 1 after E0. Latency 1.
- Normal division: DIV occupies cycles 1–32; `done` in cycle 33. Latency 33.
- Back-to-back: the next `start` can be accepted in the cycle after `done` (`busy`=0). Minimum issue interval is 3 cycles for MUL and 34 for DIV.
- Outputs are registered; there is no combinational path from inputs to `busy`/`done`/`result`.

## Test plan
- Reset, then MUL of 0x00000007 × 0xFFFFFFFD → `done` 2 cycles after start, `result`=0xFFFFFFEB. MULH on the same operands → 0xFFFFFFFF. MULHU → 0x00000006.
- MULHSU with `op_a`=0x80000000, `op_b`=0xFFFFFFFF → 0x80000000. MULH on the same operands → 0x00000000.
- DIV of -7 by 2 → 0xFFFFFFFD at cycle 33. REM on the same operands → 0xFFFFFFFF. DIVU of 100 by 7 → 14. REMU → 2. `busy` is high for exactly 33 cycles.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. Both `done` 1 cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- Flush at DIV cycle 10 → IDLE next cycle, no `done`, `result` keeps its prior value. A new MUL is accepted immediately and completes normally. `start`+`flush` in the same cycle → no op accepted.
- `rst` asserted mid-division → next cycle all outputs are 0 and `busy`=0. `start` asserted while `busy`=1 is ignored, and its operands never appear on `result`.
